issue_fifo: RTL and testbench
=============================

# issue_fifo

Elastic issue buffer between the scoreboard issue port and `instr_reorder`.
- Holds up to DEPTH decoded `scoreboard_entry_t` entries, each with its control-flow flag.
- Gives the downstream stage an in-order head plus a one-entry lookahead (peek) for swap decisions.
- Throttles the scoreboard on debug requests and on outstanding control-flow instructions.

## Interface
- DEPTH, default 4: entry count; power of two, ≥2.
- clk_i  in  1  clock, all state on rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- flush_i  in  1  synchronous flush of all entries and state.
- debug_req_i  in  1  stop accepting new entries while high.
- issue_entry_i  in  scoreboard_entry_t  entry offered by the scoreboard.
- issue_entry_valid_i  in  1  issue_entry_i valid.
- is_ctrl_flow_i  in  1  offered entry is a branch or jump.
- issue_instr_ack_o  out  1  entry accepted (pushed) this cycle.
- issue_entry_o  out  scoreboard_entry_t  head entry.
- issue_entry_valid_o  out  1  head valid.
- is_ctrl_flow_o  out  1  head control-flow flag.
- issue_instr_ack_i  in  1  downstream consumed the head this cycle.
- peek_entry_o  out  scoreboard_entry_t  second-oldest entry.
- peek_valid_o  out  1  peek entry valid; requires count ≥2.
- count_o  out  $clog2(DEPTH+1)  current occupancy.

## Operation
- Storage: circular array of {sbe, is_ctrl_flow}, with write pointer, read pointer (log2 DEPTH bits, natural wrap) and count.
- Push condition: issue_instr_ack_o = issue_entry_valid_i & (count != DEPTH) & !ctrl_pending_q & !debug_req_i & !flush_i.
  - Uses registered state only; there is no combinational path from issue_instr_ack_i.
- Pop condition: pop = issue_instr_ack_i & issue_entry_valid_o. An ack while empty is ignored.
- Simultaneous push and pop: count unchanged and both pointers advance. This is legal at any count < DEPTH.
- Control-flow throttle:
  - ctrl_pending_q sets when an entry with is_ctrl_flow_i=1 is pushed.
  - It clears when an entry with is_ctrl_flow=1 is popped.
  - While it is set, no further pushes occur, so at most one control-flow instruction is buffered and it is always the youngest entry.
  - Pop of a control-flow entry plus push in the same cycle cannot happen, because push is blocked by ctrl_pending_q.
- Outputs:
  - issue_entry_o = mem[rd_ptr].
  - issue_entry_valid_o = (count != 0) & !flush_i.
  - is_ctrl_flow_o = mem[rd_ptr].is_ctrl_flow.
  - peek_entry_o = mem[rd_ptr+1].
  - peek_valid_o = (count ≥ 2) & !flush_i.
- Flush: next state is pointers=0, count=0, ctrl_pending=0. During the flush cycle, valid outputs are forced to 0 and ack_o is 0. Flush has priority over a simultaneous push or pop.
- debug_req_i only blocks pushes. Pops continue, so the buffer drains.
- Reset values:
  - count_o=0, valid outputs 0, issue_instr_ack_o=0 (valid_i low), ctrl_pending=0.
  - Storage is cleared to '0, so issue_entry_o, peek_entry_o and is_ctrl_flow_o read '0.

## Timing
- Push-to-head latency is 1 cycle: an entry pushed in cycle N appears on issue_entry_o in N+1 when the buffer is empty. There is no bypass.
- Sustained throughput is 1 entry/cycle with simultaneous push/pop.
- Full state: ack_o goes low in the cycle count reaches DEPTH. It returns high one cycle after a pop.
- After flush in cycle N, the first push can occur in N+1 and appears on the head in N+2.
- Reset asserted mid-operation clears everything immediately (asynchronous). Outputs are valid-low until the first push after release.

## Structure
- scoreboard_entry_t and fu_t come from ariane_pkg.
- Add ISSUE_FIFO_DEPTH (default 4) to ariane_pkg; the top level instantiates with it.
- No sub-module: the storage is inline, because peek access excludes fifo_v3.
- The block instantiates between the scoreboard issue port and instr_reorder in issue_stage.

## Test plan
- Fill: push 4 ALU entries with no ack_i.
  - count_o goes 1,2,3,4; ack_o=0 in the cycle after count=4.
  - Head is entry 0 and peek is entry 1.
- Streaming: valid_i and ack_i both high continuously for 16 cycles.
  - count stays 1 after the first cycle.
  - Outputs follow input order with 1-cycle latency across pointer wrap.
- Control flow: push a BRANCH entry, then offer an ALU entry.
  - ack_o=0 until the BRANCH is popped.
  - ack_o=1 in the cycle after that pop.
- Flush at count=3 with valid_i and ack_i high: the next cycle has count_o=0, valid outputs 0 and ctrl_pending clear.
- debug_req_i high at count=2 with ack_i=1: no pushes, count goes 1 then 0, and ack_o stays 0 until debug_req_i falls.
- Asynchronous reset mid-stream at count=3: all outputs reach their reset values without a clock edge; the first push after release appears on the head after 1 cycle.

Source files
------------

// File: rtl/ariane_pkg.sv
// Shared core types: functional-unit encoding, the decoded scoreboard entry,
// and the issue buffer depth used by issue_stage.
package ariane_pkg;

  localparam int unsigned ISSUE_FIFO_DEPTH = 4;

  typedef enum logic [2:0] {
    NONE,
    LOAD,
    STORE,
    ALU,
    BRANCH,
    MULT,
    CSR
  } fu_t;

  typedef struct packed {
    logic [31:0] pc;
    fu_t         fu;
    logic [6:0]  op;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] result;
    logic        valid;
  } scoreboard_entry_t;

endpackage

// File: rtl/issue_fifo.sv
// Elastic issue buffer between the scoreboard issue port and instr_reorder:
// in-order head plus a one-entry peek, throttled on debug and on a buffered branch.
module issue_fifo
  import ariane_pkg::*;
#(
  parameter int unsigned DEPTH = ISSUE_FIFO_DEPTH
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       debug_req_i,
  input  scoreboard_entry_t          issue_entry_i,
  input  logic                       issue_entry_valid_i,
  input  logic                       is_ctrl_flow_i,
  output logic                       issue_instr_ack_o,
  output scoreboard_entry_t          issue_entry_o,
  output logic                       issue_entry_valid_o,
  output logic                       is_ctrl_flow_o,
  input  logic                       issue_instr_ack_i,
  output scoreboard_entry_t          peek_entry_o,
  output logic                       peek_valid_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    scoreboard_entry_t sbe;
    logic              is_ctrl_flow;
  } slot_t;

  slot_t            mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ctrl_pending_q, ctrl_pending_d;
  logic             push, pop;
  slot_t            head, peek;

  assign head = mem_q[rd_ptr_q];
  assign peek = mem_q[rd_ptr_q + PTR_W'(1)];

  // Acceptance depends only on registered state and upstream inputs, never on issue_instr_ack_i.
  assign push = issue_entry_valid_i & (count_q != CNT_W'(DEPTH)) & ~ctrl_pending_q
              & ~debug_req_i & ~flush_i;
  assign pop  = issue_instr_ack_i & issue_entry_valid_o;

  assign issue_instr_ack_o   = push;
  assign issue_entry_o       = head.sbe;
  assign is_ctrl_flow_o      = head.is_ctrl_flow;
  assign issue_entry_valid_o = (count_q != '0) & ~flush_i;
  assign peek_entry_o        = peek.sbe;
  assign peek_valid_o        = (count_q >= CNT_W'(2)) & ~flush_i;
  assign count_o             = count_q;

  always_comb begin
    // NOTE: every next-state signal takes its hold value first, so no path infers a latch.
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    count_d        = count_q;
    ctrl_pending_d = ctrl_pending_q;
    if (flush_i) begin
      wr_ptr_d       = '0;
      rd_ptr_d       = '0;
      count_d        = '0;
      ctrl_pending_d = 1'b0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (is_ctrl_flow_i) ctrl_pending_d = 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (head.is_ctrl_flow) ctrl_pending_d = 1'b0;
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!rst_ni) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      ctrl_pending_q <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      ctrl_pending_q <= ctrl_pending_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      // NOTE: storage is reset so head and peek read '0 out of reset instead of X.
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q] <= '{sbe: issue_entry_i, is_ctrl_flow: is_ctrl_flow_i};
    end
  end

endmodule

// File: tb/tb_issue_fifo.sv
// Self-checking bench for issue_fifo: directed scenarios plus a random phase,
// every cycle compared against a queue-based reference model.
module tb_issue_fifo;
  import ariane_pkg::*;

  localparam int unsigned DEPTH = ISSUE_FIFO_DEPTH;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  typedef struct packed {
    scoreboard_entry_t sbe;
    logic              cf;
  } m_slot_t;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic              flush_i;
  logic              debug_req_i;
  scoreboard_entry_t issue_entry_i;
  logic              issue_entry_valid_i;
  logic              is_ctrl_flow_i;
  logic              issue_instr_ack_o;
  scoreboard_entry_t issue_entry_o;
  logic              issue_entry_valid_o;
  logic              is_ctrl_flow_o;
  logic              issue_instr_ack_i;
  scoreboard_entry_t peek_entry_o;
  logic              peek_valid_o;
  logic [CW-1:0]     count_o;

  int n_asserts = 0;
  int n_fails   = 0;
  m_slot_t q[$];

  always #5 clk_i = ~clk_i;

  issue_fifo #(.DEPTH(DEPTH)) dut (
    .clk_i               (clk_i),
    .rst_ni              (rst_ni),
    .flush_i             (flush_i),
    .debug_req_i         (debug_req_i),
    .issue_entry_i       (issue_entry_i),
    .issue_entry_valid_i (issue_entry_valid_i),
    .is_ctrl_flow_i      (is_ctrl_flow_i),
    .issue_instr_ack_o   (issue_instr_ack_o),
    .issue_entry_o       (issue_entry_o),
    .issue_entry_valid_o (issue_entry_valid_o),
    .is_ctrl_flow_o      (is_ctrl_flow_o),
    .issue_instr_ack_i   (issue_instr_ack_i),
    .peek_entry_o        (peek_entry_o),
    .peek_valid_o        (peek_valid_o),
    .count_o             (count_o)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic scoreboard_entry_t rand_entry(input logic cf);
    scoreboard_entry_t e;
    e.pc     = $urandom;
    e.fu     = cf ? BRANCH : ALU;
    e.op     = 7'($urandom);
    e.rs1    = 5'($urandom);
    e.rs2    = 5'($urandom);
    e.rd     = 5'($urandom);
    e.result = $urandom;
    e.valid  = 1'b1;
    return e;
  endfunction

  // Reference rules: a branch in the buffer blocks pushes until it leaves.
  function automatic bit model_pending();
    foreach (q[i]) if (q[i].cf) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit model_ack();
    return issue_entry_valid_i && (q.size() < DEPTH) && !model_pending()
        && !debug_req_i && !flush_i;
  endfunction

  function automatic bit model_pop();
    return issue_instr_ack_i && (q.size() != 0) && !flush_i;
  endfunction

  task automatic compare_outputs();
    int n;
    n = flush_i ? 0 : q.size();
    check("ack_o", 128'(issue_instr_ack_o), 128'(model_ack()));
    check("valid_o", 128'(issue_entry_valid_o), 128'(n >= 1));
    check("peek_valid_o", 128'(peek_valid_o), 128'(n >= 2));
    check("count_o", 128'(count_o), 128'(q.size()));
    if (q.size() >= 1) begin
      check("head_entry", 128'(issue_entry_o), 128'(q[0].sbe));
      check("head_ctrl_flow", 128'(is_ctrl_flow_o), 128'(q[0].cf));
    end
    if (q.size() >= 2) check("peek_entry", 128'(peek_entry_o), 128'(q[1].sbe));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_count"}, 128'(count_o), 128'(0));
    check({tag, "_valid"}, 128'(issue_entry_valid_o), 128'(0));
    check({tag, "_peek_valid"}, 128'(peek_valid_o), 128'(0));
    check({tag, "_ack"}, 128'(issue_instr_ack_o), 128'(0));
    check({tag, "_head"}, 128'(issue_entry_o), 128'(0));
    check({tag, "_peek"}, 128'(peek_entry_o), 128'(0));
    check({tag, "_ctrl_flow"}, 128'(is_ctrl_flow_o), 128'(0));
  endtask

  // Inputs are set just after a rising edge; outputs are checked on the falling edge.
  task automatic cycle();
    bit do_push, do_pop;
    @(negedge clk_i);
    compare_outputs();
    do_push = model_ack();
    do_pop  = model_pop();
    @(posedge clk_i);
    if (flush_i) q.delete();
    else begin
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(m_slot_t'{sbe: issue_entry_i, cf: is_ctrl_flow_i});
    end
    #1;
    issue_entry_i = rand_entry(is_ctrl_flow_i);
  endtask

  task automatic drive(input logic v, input logic a, input logic cf);
    issue_entry_valid_i = v;
    issue_instr_ack_i   = a;
    is_ctrl_flow_i      = cf;
    issue_entry_i       = rand_entry(cf);
  endtask

  task automatic fill_to(input int n);
    drive(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 2 * DEPTH && q.size() < n; i++) cycle();
    check("fill_level", 128'(q.size()), 128'(n));
  endtask

  task automatic drain();
    drive(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < DEPTH + 1; i++) cycle();
  endtask

  initial begin
    rst_ni      = 1'b0;
    flush_i     = 1'b0;
    debug_req_i = 1'b0;
    drive(1'b0, 1'b0, 1'b0);
    #3;
    check_reset_outputs("reset");
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // Fill without consuming: count 1..DEPTH, then ack_o drops.
    drive(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH + 2; i++) cycle();
    check("full_count", 128'(count_o), 128'(DEPTH));
    check("full_ack_low", 128'(issue_instr_ack_o), 128'(0));
    drain();

    // Streaming across pointer wrap.
    drive(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) cycle();
    check("stream_count", 128'(count_o), 128'(1));
    drain();

    // Branch throttle: ALU offered behind a buffered branch waits for its pop.
    drive(1'b1, 1'b0, 1'b1);
    cycle();
    drive(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle();
    issue_instr_ack_i = 1'b1;
    cycle();
    issue_instr_ack_i = 1'b0;
    check("ack_after_branch_pop", 128'(issue_instr_ack_o), 128'(1));
    cycle();
    drain();

    // Flush at count 3 with push and pop offered.
    fill_to(3);
    drive(1'b1, 1'b1, 1'b0);
    flush_i = 1'b1;
    cycle();
    flush_i = 1'b0;
    drive(1'b0, 1'b0, 1'b0);
    cycle();
    drive(1'b1, 1'b0, 1'b1);
    cycle();
    check("flush_cleared_pending", 128'(issue_instr_ack_o), 128'(0));
    drain();

    // Debug request at count 2: drains, no pushes until it falls.
    fill_to(2);
    drive(1'b1, 1'b1, 1'b0);
    debug_req_i = 1'b1;
    for (int i = 0; i < 4; i++) cycle();
    debug_req_i = 1'b0;
    cycle();
    cycle();
    drain();

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      drive(($urandom_range(3) != 0), $urandom_range(1), ($urandom_range(7) == 0));
      debug_req_i = ($urandom_range(9) == 0);
      flush_i     = ($urandom_range(29) == 0);
      cycle();
    end
    flush_i     = 1'b0;
    debug_req_i = 1'b0;
    drain();

    // Asynchronous reset mid-cycle at count 3.
    fill_to(3);
    drive(1'b0, 1'b0, 1'b0);
    #2;
    rst_ni = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    q.delete();
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    drive(1'b1, 1'b0, 1'b0);
    cycle();
    drive(1'b0, 1'b0, 1'b0);
    cycle();
    check("post_reset_count", 128'(count_o), 128'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
